// File: rtl/pipe_latch_skid.sv
// Two-entry pipeline latch with skid register: in_ready comes only from the state register,
// so no combinational path runs from out_ready to in_ready. flush and reset empty the stage.
module pipe_latch_skid #(
  parameter int unsigned           WIDTH  = 32,
  parameter int unsigned           FIELDS = 4,
  parameter logic [WIDTH-1:0]      BUBBLE = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FIELDS*WIDTH-1:0]   in_data,
  input  logic                      in_exc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FIELDS*WIDTH-1:0]   out_data,
  output logic                      out_exc,
  output logic [1:0]                occupancy
);

  localparam int unsigned DW = FIELDS * WIDTH;

  // State values equal the occupancy count, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [DW-1:0]   main_data;
  logic [DW-1:0]   skid_data;
  logic [DW-1:0]   bubble_data;
  logic            main_exc;
  logic            skid_exc;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid_in;

  assign bubble_data = {FIELDS{BUBBLE}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_valid) begin
          load_skid_in = 1'b1;
          state_next   = TWO;
        end else if (out_ready) begin
          state_next   = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    // The downstream transfer at a flush edge still completes; flush only kills what remains.
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      main_data <= bubble_data;
      main_exc  <= 1'b0;
      skid_data <= bubble_data;
      skid_exc  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_exc  <= in_exc;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_exc  <= skid_exc;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
        skid_exc  <= in_exc;
      end
    end
  end

  always_comb begin
    in_ready  = (state != TWO);
    out_valid = (state != EMPTY);
    out_data  = out_valid ? main_data : bubble_data;
    out_exc   = out_valid & main_exc;
    occupancy = state;
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Randomized bench for pipe_latch_skid against a queue-based model of a two-entry FIFO stage.
module tb_pipe_latch_skid;

  localparam int unsigned W  = 8;
  localparam int unsigned F  = 4;
  localparam int unsigned DW = W * F;
  localparam logic [W-1:0]  BUB      = 8'h5A;
  localparam logic [DW-1:0] BUB_WORD = {F{BUB}};

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, in_exc, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, out_exc;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int passed = 0;

  // Model: queue of {exc, data}, capacity two, head at index 0.
  logic [DW:0] mq[$];

  pipe_latch_skid #(.WIDTH(W), .FIELDS(F), .BUBBLE(BUB)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic [DW+4:0] exp_vec();
    logic [DW:0] h;
    if (mq.size() == 0) return {1'b1, 1'b0, 1'b0, 2'd0, BUB_WORD};
    h = mq[0];
    return {mq.size() < 2, 1'b1, h[DW], 2'(mq.size()), h[DW-1:0]};
  endfunction

  function automatic logic [DW+4:0] obs_vec();
    return {in_ready, out_valid, out_exc, occupancy, out_data};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic ordy, input logic fl, input logic rst);
    in_valid = v; in_data = d; in_exc = e; out_ready = ordy; flush = fl; reset = rst;
  endtask

  // Advance one edge; the model sees exactly the inputs the DUT samples.
  task automatic tick();
    bit ofire, ifire;
    @(posedge clock);
    ofire = (mq.size() > 0) && out_ready;
    ifire = in_valid && (mq.size() < 2);
    if (reset) mq.delete();
    else begin
      if (ofire) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (ifire) mq.push_back({in_exc, in_data});
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if ({in_ready, out_valid, out_exc, occupancy} !== 5'b1_0_0_00)
      $display("FAIL reset_ctrl got %b want 10000", {in_ready, out_valid, out_exc, occupancy});
    else passed++;
    checks++;
    if (out_data !== BUB_WORD) $display("FAIL reset_data got %h want %h", out_data, BUB_WORD);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 32'h13121110, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, occupancy, out_data} !== {1'b1, 2'd1, 32'h13121110})
      $display("FAIL single got v=%b occ=%0d d=%h want v=1 occ=1 d=13121110", out_valid, occupancy, out_data);
    else passed++;
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL single_model got %h want %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_stall_order();
    logic [DW-1:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    do_reset();
    drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_data = b;
    tick();
    checks++;
    if ({in_ready, occupancy, out_data} !== {1'b0, 2'd2, a})
      $display("FAIL stall_two got rdy=%b occ=%0d d=%h want rdy=0 occ=2 d=%h", in_ready, occupancy, out_data, a);
    else passed++;
    in_data = c;
    tick();
    checks++;
    if ({in_ready, occupancy, out_data} !== {1'b0, 2'd2, a})
      $display("FAIL stall_hold got rdy=%b occ=%0d d=%h want rdy=0 occ=2 d=%h", in_ready, occupancy, out_data, a);
    else passed++;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({occupancy, out_data} !== {2'd1, b})
      $display("FAIL stall_drain_b got occ=%0d d=%h want occ=1 d=%h", occupancy, out_data, b);
    else passed++;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({occupancy, out_data} !== {2'd1, c})
      $display("FAIL stall_drain_c got occ=%0d d=%h want occ=1 d=%h", occupancy, out_data, c);
    else passed++;
    tick();
    checks++;
    if ({out_valid, occupancy} !== 3'b0_00)
      $display("FAIL stall_empty got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    else passed++;
  endtask

  task automatic test_flush_two();
    do_reset();
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    in_data = $urandom;
    tick();
    flush = 1'b1; in_data = $urandom;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_exc, occupancy, out_data} !== {5'b1_0_0_00, BUB_WORD})
      $display("FAIL flush_two got %b_%h want 10000_%h",
               {in_ready, out_valid, out_exc, occupancy}, out_data, BUB_WORD);
    else passed++;
  endtask

  task automatic test_flush_pop();
    do_reset();
    drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_data = $urandom; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, occupancy, out_data} !== {3'b0_00, BUB_WORD})
      $display("FAIL flush_pop got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", out_valid, occupancy, out_data, BUB_WORD);
    else passed++;
  endtask

  task automatic test_throughput();
    logic [DW-1:0] ent[10];
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ent[i] = $urandom;
      drive(1'b1, ent[i], 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      if ({in_ready, occupancy, out_data} !== {1'b1, 2'd1, ent[i]}) begin
        $display("FAIL throughput[%0d] got rdy=%b occ=%0d d=%h want rdy=1 occ=1 d=%h",
                 i, in_ready, occupancy, out_data, ent[i]);
        bad++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (bad == 0) passed++;
  endtask

  task automatic test_exc();
    logic [DW-1:0] tags[4];
    int idx, cyc;
    tags = '{32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
    idx = 0; cyc = 0;
    do_reset();
    while ((idx < 4 || mq.size() != 0) && cyc < 60) begin
      drive(idx < 4, tags[idx % 4], idx == 1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (in_valid && mq.size() < 2) idx++;
      tick();
      cyc++;
      checks++;
      if (out_exc !== (out_valid && out_data == tags[1]))
        $display("FAIL exc_head cyc=%0d got exc=%b head=%h", cyc, out_exc, out_data);
      else passed++;
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL exc_model got %h want %h", obs_vec(), exp_vec());
      else passed++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 60) $display("FAIL exc_drain got pending=%0d want 0 within 60 cycles", mq.size());
    else passed++;
  endtask

  task automatic test_reset_two();
    do_reset();
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    in_data = $urandom;
    tick();
    in_data = $urandom; reset = 1'b1; out_ready = 1'($urandom_range(0, 1));
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_exc, occupancy, out_data} !== {5'b1_0_0_00, BUB_WORD})
      $display("FAIL reset_two got %b_%h want 10000_%h",
               {in_ready, out_valid, out_exc, occupancy}, out_data, BUB_WORD);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random[%0d] got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_single();
    test_stall_order();
    test_flush_two();
    test_flush_pop();
    test_throughput();
    test_exc();
    test_reset_two();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one field.
REQ-002 Parameter FIELDS, default 4, number of WIDTH-bit fields carried per stage (pc, pc+1, insn, operand, ...).
REQ-003 Parameter BUBBLE, default 0, WIDTH-bit value driven in every output field when the stage is empty.
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port flush  input  1  synchronous kill of all held entries (branch mispredict / exception).
REQ-007 Port in_valid  input  1  upstream presents an entry.
REQ-008 Port in_ready  output  1  stage can accept an entry this cycle.
REQ-009 Port in_data  input  FIELDS*WIDTH  upstream fields, field k at bits [k*WIDTH +: WIDTH].
REQ-010 Port in_exc  input  1  upstream exception flag travelling with the entry.
REQ-011 Port out_valid  output  1  stage presents an entry downstream.
REQ-012 Port out_ready  input  1  downstream accepts (low = stall).
REQ-013 Port out_data  output  FIELDS*WIDTH  head entry fields.
REQ-014 Port out_exc  output  1  head entry exception flag.
REQ-015 Port occupancy  output  2  entries held: 0, 1 or 2.

Function
REQ-016 Transfer = valid AND ready sampled at a rising edge, on either side, independently.
REQ-017 Storage: main register (head) plus skid register, each FIELDS*WIDTH+1 bits (data + exc).
REQ-018 States: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full); encoded as occupancy.
REQ-019 in_ready = (state != TWO), decoded from state register only, never combinationally from out_ready.
REQ-020 out_valid = (state != EMPTY); out_data/out_exc = main contents when valid, BUBBLE replicated FIELDS times / 0 when EMPTY.
REQ-021 EMPTY: in_valid -> main <= in, go ONE; else stay.
REQ-022 ONE: in_valid & out_ready -> main <= in, stay ONE; in_valid & !out_ready -> skid <= in, go TWO; !in_valid & out_ready -> go EMPTY; neither -> hold.
REQ-023 TWO: out_ready -> main <= skid, go ONE; else hold; no input accepted (in_ready=0).
REQ-024 Latency: entry accepted at edge N appears on out_data after edge N (one cycle) when stage was EMPTY, or when ONE with out_ready high.
REQ-025 Order: entries leave strictly in acceptance order; no entry duplicated or dropped except by flush.
REQ-026 Held contents do not change while out_valid=1 and out_ready=0 (stall stability).
REQ-027 flush has priority over all transfers: next state EMPTY, main and skid loaded with BUBBLE/0, in_data that cycle discarded even if in_valid & in_ready.
REQ-028 flush asserted with out_ready high: the downstream transfer at that edge completes normally; flush kills only what remains.
REQ-029 occupancy never exceeds 2; no state other than EMPTY/ONE/TWO reachable.

Reset
REQ-030 reset has priority over flush and all transfers.
REQ-031 After reset edge: state EMPTY, occupancy 0, in_ready 1, out_valid 0, out_exc 0, out_data = BUBBLE in every field, skid cleared.
REQ-032 Reset mid-operation (ONE or TWO) discards both entries in the same edge.

Verification
REQ-033 Reset, then in_valid=1 in_data fields {0x10,0x11,0x12,0x13}, out_ready=1 -> next cycle out_valid=1, out_data={0x10,0x11,0x12,0x13}, occupancy 1.
REQ-034 Stream A,B,C with out_ready=0 from cycle 1 -> occupancy 2 after B, in_ready=0, C held upstream; out_ready=1 for 3 cycles -> outputs A,B,C in order, no loss.
REQ-035 Stage in TWO, flush=1, in_valid=1 -> next cycle occupancy 0, out_valid=0, out_data=BUBBLE (0) all fields, in_ready=1.
REQ-036 Full-throughput: in_valid=1 and out_ready=1 every cycle for 10 entries -> one entry out per cycle, occupancy stays 1, in_ready never 0.
REQ-037 in_exc=1 on entry B only, random out_ready stalls -> out_exc=1 exactly while B is head.
REQ-038 Reset asserted while in TWO with flush=0, in_valid=1 -> next cycle occupancy 0, out_valid=0, out_exc=0, input not captured.
